stepper_spi_master: RTL and testbench

STEPPER_SPI_MASTER -- requirements
Module: stepper_spi_master

---
 rtl/stepper_spi_pkg.sv | 31 +++
 rtl/stepper_spi_master_clk_divider.sv | 30 +++
 rtl/stepper_spi_master.sv | 118 +++++++++++
 tb/tb_stepper_spi_master.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_spi_pkg.sv
// Shared types and constants for the stepper-driver SPI master:
// FSM state encoding, default timing parameters and driver command bytes.
package stepper_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CS_SETUP  = 3'd1,
    ST_SHIFT     = 3'd2,
    ST_WAIT_NEXT = 3'd3,
    ST_CS_HOLD   = 3'd4,
    ST_CS_GAP    = 3'd5
  } spi_state_e;

  localparam int DEFAULT_CLKS_PER_HALF_BIT = 4;
  localparam int DEFAULT_CS_INACTIVE_CLKS  = 8;

  // Driver command bytes; bit 7 set marks a register write.
  localparam logic [7:0] CMD_NOP           = 8'h00;
  localparam logic [7:0] CMD_READ_STATUS   = 8'h01;
  localparam logic [7:0] CMD_READ_POSITION = 8'h02;
  localparam logic [7:0] CMD_WRITE_CONFIG  = 8'h80;
  localparam logic [7:0] CMD_SET_MICROSTEP = 8'h81;
  localparam logic [7:0] CMD_SET_CURRENT   = 8'h82;
  localparam logic [7:0] CMD_ENABLE        = 8'h83;
  localparam logic [7:0] CMD_DISABLE       = 8'h84;

  function automatic logic cmd_is_write(input logic [7:0] cmd);
    return cmd[7];
  endfunction

endpackage

// File: rtl/stepper_spi_master_clk_divider.sv
// Half-period tick generator: while enabled, tick pulses on every
// CLKS_PER_HALF_BIT-th cycle; disabling reloads the down-counter.
import stepper_spi_pkg::*;

module spi_clk_divider #(
  parameter int CLKS_PER_HALF_BIT = DEFAULT_CLKS_PER_HALF_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam logic [7:0] RELOAD = 8'(CLKS_PER_HALF_BIT - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = RELOAD;
    if (enable && (cnt_q != 8'd0)) cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= RELOAD;
    else        cnt_q <= cnt_d;
  end

  assign tick = enable && (cnt_q == 8'd0);

endmodule

// File: rtl/stepper_spi_master.sv
// SPI mode-0 master for the stepper driver: byte-wide transmit handshake,
// chip-select framing with bursts, setup/hold and minimum CS_n high time.
import stepper_spi_pkg::*;

module stepper_spi_master #(
  parameter int CLKS_PER_HALF_BIT = DEFAULT_CLKS_PER_HALF_BIT,
  parameter int CS_INACTIVE_CLKS  = DEFAULT_CS_INACTIVE_CLKS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_dv,
  input  logic       i_tx_last,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_dv,
  output logic       o_spi_clk,
  output logic       o_spi_mosi,
  input  logic       i_spi_miso,
  output logic       o_spi_cs_n
);

  localparam logic [7:0] GAP_RELOAD = 8'(CS_INACTIVE_CLKS - 1);

  spi_state_e state_q, state_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_dv_q, rx_dv_d;
  logic       last_q, last_d;
  logic [3:0] half_idx_q, half_idx_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic       div_en, tick, accept, byte_done;

  // The divider also runs on the WAIT_NEXT accept cycle so that cycle counts
  // toward the first low half of the next byte, keeping a burst at 16 halves.
  assign div_en = (state_q == ST_CS_SETUP) || (state_q == ST_SHIFT) ||
                  (state_q == ST_CS_HOLD)  || ((state_q == ST_WAIT_NEXT) && i_tx_dv);
  assign accept    = ((state_q == ST_IDLE) || (state_q == ST_WAIT_NEXT)) && i_tx_dv;
  assign byte_done = (state_q == ST_SHIFT) && tick && (half_idx_q == 4'd15);

  spi_clk_divider #(.CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (div_en),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (i_tx_dv) state_d = ST_CS_SETUP;
      ST_CS_SETUP:  if (tick) state_d = ST_SHIFT;
      ST_SHIFT:     if (byte_done) state_d = last_q ? ST_CS_HOLD : ST_WAIT_NEXT;
      ST_WAIT_NEXT: if (i_tx_dv) state_d = ST_SHIFT;
      ST_CS_HOLD:   if (tick) state_d = ST_CS_GAP;
      ST_CS_GAP:    if (gap_cnt_q == 8'd0) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_tx_ready = (state_q == ST_IDLE) || (state_q == ST_WAIT_NEXT);
    o_spi_cs_n = (state_q == ST_IDLE) || (state_q == ST_CS_GAP);
    o_spi_clk  = (state_q == ST_SHIFT) && half_idx_q[0];
    o_spi_mosi = !o_spi_cs_n && tx_shift_q[7];
    o_rx_byte  = rx_byte_q;
    o_rx_dv    = rx_dv_q;
  end

  // Even half index ends a low half (SCLK rises), odd ends a high half (SCLK falls).
  always_comb begin
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    last_d     = last_q;
    half_idx_d = half_idx_q;
    gap_cnt_d  = gap_cnt_q;
    rx_dv_d    = byte_done;
    rx_byte_d  = byte_done ? rx_shift_q : rx_byte_q;
    if (accept) begin
      tx_shift_d = i_tx_byte;
      last_d     = i_tx_last;
      half_idx_d = 4'd0;
    end else if ((state_q == ST_SHIFT) && tick) begin
      half_idx_d = half_idx_q + 4'd1;
      if (half_idx_q[0]) tx_shift_d = {tx_shift_q[6:0], 1'b0};
      else               rx_shift_d = {rx_shift_q[6:0], i_spi_miso};
    end
    if ((state_q == ST_CS_HOLD) && tick)                    gap_cnt_d = GAP_RELOAD;
    else if ((state_q == ST_CS_GAP) && (gap_cnt_q != 8'd0)) gap_cnt_d = gap_cnt_q - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_shift_q <= 8'h00;
      rx_shift_q <= 8'h00;
      rx_byte_q  <= 8'h00;
      rx_dv_q    <= 1'b0;
      last_q     <= 1'b0;
      half_idx_q <= 4'd0;
      gap_cnt_q  <= 8'd0;
    end else begin
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_dv_q    <= rx_dv_d;
      last_q     <= last_d;
      half_idx_q <= half_idx_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_stepper_spi_master.sv
// Self-checking bench: a bus-level SPI slave model and frame scoreboard
// compare the DUT against expected bytes, frame lengths and CS_n gaps.
module tb_stepper_spi_master;

  localparam int H   = 2;
  localparam int GAP = 8;
  localparam int TMO = 2000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_tx_byte;
  logic       i_tx_dv, i_tx_last, i_spi_miso;
  logic       o_tx_ready, o_rx_dv, o_spi_clk, o_spi_mosi, o_spi_cs_n;
  logic [7:0] o_rx_byte;

  logic       loopback, slave_miso;
  assign i_spi_miso = loopback ? o_spi_mosi : slave_miso;

  always #5 clk = ~clk;

  stepper_spi_master #(.CLKS_PER_HALF_BIT(H), .CS_INACTIVE_CLKS(GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_tx_byte  (i_tx_byte),
    .i_tx_dv    (i_tx_dv),
    .i_tx_last  (i_tx_last),
    .o_tx_ready (o_tx_ready),
    .o_rx_byte  (o_rx_byte),
    .o_rx_dv    (o_rx_dv),
    .o_spi_clk  (o_spi_clk),
    .o_spi_mosi (o_spi_mosi),
    .i_spi_miso (i_spi_miso),
    .o_spi_cs_n (o_spi_cs_n)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard state
  logic [7:0] exp_mosi[$];
  logic [7:0] exp_rx[$];
  logic [7:0] slave_q[$];
  int frame_n = 0;
  int rises_total = 0;

  // Bus monitor / slave model state
  logic       prev_cs = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;
  logic       cs, sck;
  logic [7:0] cap = 8'h00, slave_sh = 8'h00;
  int bitcnt = 0, low_cnt = 0, gap_cnt = 0, frame_rises = 0, frame_dv = 0;
  bit aborted = 1'b0, have_prev = 1'b0;

  always @(negedge clk) begin
    cs  = o_spi_cs_n;
    sck = o_spi_clk;
    if (prev_cs === 1'b1 && cs === 1'b0) begin
      if (have_prev) chk("cs_gap_min", 32'(gap_cnt >= GAP), 1);
      aborted = 1'b0;
      low_cnt = 0; frame_rises = 0; frame_dv = 0; bitcnt = 0;
      slave_sh = (slave_q.size() != 0) ? slave_q.pop_front() : 8'h00;
      slave_miso = slave_sh[7];
    end
    if (o_rx_dv === 1'b1) begin
      if (exp_rx.size() == 0) chk("rx_dv_unexpected", 1, 0);
      else chk("rx_byte", o_rx_byte, exp_rx.pop_front());
      frame_dv++;
    end
    if (cs === 1'b0) low_cnt++;
    if (sck === 1'b1 && prev_sck === 1'b0) begin
      cap = {cap[6:0], o_spi_mosi};
      bitcnt++; frame_rises++; rises_total++;
    end
    if (sck === 1'b0 && prev_sck === 1'b1) begin
      if (bitcnt == 8) begin
        if (exp_mosi.size() == 0) chk("mosi_byte_unexpected", 1, 0);
        else chk("mosi_byte", cap, exp_mosi.pop_front());
        bitcnt = 0;
        slave_sh = (slave_q.size() != 0) ? slave_q.pop_front() : 8'h00;
      end else begin
        slave_sh = slave_sh << 1;
      end
      slave_miso = slave_sh[7];
    end
    if (sck === 1'b1 && prev_sck === 1'b1 && cs === 1'b0)
      chk("mosi_stable_sclk_high", o_spi_mosi, prev_mosi);
    if (prev_cs === 1'b0 && cs === 1'b1) begin
      if (!aborted) begin
        chk("cs_low_cycles", low_cnt, (16 * frame_n + 2) * H);
        chk("sclk_rises", frame_rises, 8 * frame_n);
        chk("rx_dv_count", frame_dv, frame_n);
        have_prev = 1'b1;
      end
      gap_cnt = 0;
    end
    if (cs === 1'b1) begin
      gap_cnt++;
      chk("mosi_zero_cs_high", o_spi_mosi, 0);
    end
    if (rst_n === 1'b0) begin
      aborted = 1'b1; have_prev = 1'b0; bitcnt = 0;
      exp_mosi.delete(); exp_rx.delete(); slave_q.delete();
    end
    prev_cs = cs; prev_sck = sck; prev_mosi = o_spi_mosi;
  end

  task automatic wait_ready();
    int t = 0;
    while (!o_tx_ready && t < TMO) begin
      @(posedge clk); #1; t++;
    end
    if (!o_tx_ready) chk("tx_ready_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(o_tx_ready && o_spi_cs_n) && t < TMO) begin
      @(posedge clk); #1; t++;
    end
    if (!(o_tx_ready && o_spi_cs_n)) chk("idle_timeout", 0, 1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    wait_ready();
    i_tx_byte = b; i_tx_last = last; i_tx_dv = 1'b1;
    exp_mosi.push_back(b);
    if (loopback) exp_rx.push_back(b);
    @(posedge clk); #1;
    i_tx_dv = 1'b0;
  endtask

  task automatic do_frame(input int n, input logic [7:0] tx [4], input logic [7:0] rx [4]);
    wait_ready();
    frame_n = n;
    if (!loopback)
      for (int i = 0; i < n; i++) begin
        slave_q.push_back(rx[i]);
        exp_rx.push_back(rx[i]);
      end
    for (int i = 0; i < n; i++) send_byte(tx[i], i == n - 1);
  endtask

  logic [7:0] tx_a [4];
  logic [7:0] rx_a [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base, t;
    i_tx_byte = 8'h00; i_tx_dv = 1'b0; i_tx_last = 1'b0;
    loopback = 1'b0; slave_miso = 1'b0; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", o_spi_cs_n, 1);
    chk("rst_sclk", o_spi_clk, 0);
    chk("rst_mosi", o_spi_mosi, 0);
    chk("rst_rx_dv", o_rx_dv, 0);
    chk("rst_rx_byte", o_rx_byte, 0);
    chk("rst_tx_ready", o_tx_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single looped-back byte
    loopback = 1'b1;
    tx_a[0] = 8'hA5;
    do_frame(1, tx_a, rx_a);
    wait_idle();
    chk("single_rx_hold", o_rx_byte, 8'hA5);

    // Two-byte burst with slave responses
    loopback = 1'b0;
    tx_a[0] = 8'h12; tx_a[1] = 8'h34;
    rx_a[0] = 8'hC3; rx_a[1] = 8'h3C;
    do_frame(2, tx_a, rx_a);
    wait_idle();

    // Back-to-back frames, second issued as soon as ready returns
    tx_a[0] = 8'h81; rx_a[0] = 8'h6E;
    do_frame(1, tx_a, rx_a);
    tx_a[0] = 8'h02; rx_a[0] = 8'h91;
    do_frame(1, tx_a, rx_a);
    wait_idle();

    // Strobe during SHIFT must be ignored
    tx_a[0] = 8'h3C; rx_a[0] = 8'hE7;
    do_frame(1, tx_a, rx_a);
    repeat (6) begin @(posedge clk); #1; end
    chk("ready_low_in_shift", o_tx_ready, 0);
    i_tx_byte = 8'hFF; i_tx_last = 1'b0; i_tx_dv = 1'b1;
    @(posedge clk); #1;
    i_tx_dv = 1'b0;
    wait_idle();
    chk("ignored_rx_byte", o_rx_byte, 8'hE7);

    // Reset after the 4th SCLK rise
    base = rises_total;
    tx_a[0] = 8'hC6; rx_a[0] = 8'h55;
    do_frame(1, tx_a, rx_a);
    t = 0;
    while (rises_total < base + 4 && t < TMO) begin @(posedge clk); #1; t++; end
    chk("fourth_rise_seen", 32'(rises_total >= base + 4), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_cs_n", o_spi_cs_n, 1);
    chk("abort_sclk", o_spi_clk, 0);
    chk("abort_mosi", o_spi_mosi, 0);
    chk("abort_rx_dv", o_rx_dv, 0);
    rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    loopback = 1'b1;
    tx_a[0] = 8'h5A;
    do_frame(1, tx_a, rx_a);
    wait_idle();
    chk("after_reset_rx", o_rx_byte, 8'h5A);
    loopback = 1'b0;

    // Randomised frames
    for (int k = 0; k < 8; k++) begin
      int n;
      n = int'($urandom_range(1, 3));
      for (int i = 0; i < 4; i++) begin
        tx_a[i] = 8'($urandom);
        rx_a[i] = 8'($urandom);
      end
      do_frame(n, tx_a, rx_a);
      if ($urandom_range(0, 1) == 1) begin
        wait_idle();
        repeat (int'($urandom_range(0, 5))) begin @(posedge clk); #1; end
      end
    end
    wait_idle();
    repeat (5) begin @(posedge clk); #1; end
    chk("exp_mosi_drained", exp_mosi.size(), 0);
    chk("exp_rx_drained", exp_rx.size(), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
